avalon_burst_arbiter: RTL and testbench
=======================================

// Module: avalon_burst_arbiter
// PURPOSE
//  Shares the single Avalon-MM memory master between the instruction cache (port I) and the
//  data cache (port D). Grants one requester at a time, round-robin, and holds the grant for a
//  whole burst: all read beats returned, or all write beats accepted. Sits between the two
//  cache controllers and the SDRAM controller.
// PARAMETERS
//  BURST_W   5    width of burstcount on all ports (max legal burst = 16)
//  ADDR_W    32   address width
//  DATA_W    32   data width
// PORTS
//  clk              in   1       clock
//  resetn           in   1       asynchronous active-low reset
//  i_address        in   ADDR_W  I-port burst start address
//  i_read           in   1       I-port read request (I port never writes)
//  i_burstcount     in   BURST_W I-port burst length
//  i_waitrequest    out  1       I-port command stall
//  i_readdata       out  DATA_W  I-port read data (= av_readdata)
//  i_readdatavalid  out  1       I-port read beat valid
//  d_address        in   ADDR_W  D-port address
//  d_read, d_write  in   1       D-port read/write request
//  d_writedata      in   DATA_W  D-port write beat
//  d_burstcount     in   BURST_W D-port burst length
//  d_waitrequest    out  1       D-port command/beat stall
//  d_readdata       out  DATA_W  D-port read data (= av_readdata)
//  d_readdatavalid  out  1       D-port read beat valid
//  av_address/av_read/av_write/av_writedata/av_burstcount  out  shared master to memory
//  av_waitrequest, av_readdata, av_readdatavalid           in   memory responses
// BEHAVIOUR
//  - States: IDLE, RD_CMD, RD_DATA, WR_BURST. Register owner (NONE/I/D) and last (I/D).
//  - Reset (async, resetn=0): state=IDLE, owner=NONE, last=I (so D wins the first tie),
//    beat counter=0. av_read=av_write=0, av_address=av_writedata=av_burstcount=0,
//    i/d_waitrequest=1, i/d_readdatavalid=0.
//  - av_* is a combinational mux of the owner's signals. owner=NONE drives zeros.
//    The non-owner sees waitrequest=1. The owner's waitrequest equals av_waitrequest.
//  - IDLE: sample requests. Only one port requesting: grant it. Both requesting: grant the
//    port != last. Grant registers on the clock edge, so the first av_read/av_write appears
//    one cycle after the request. Write -> WR_BURST; read -> RD_CMD. Set last=granted.
//  - RD_CMD: av_read=1 until !av_waitrequest, then latch burstcount into len and go to RD_DATA.
//  - RD_DATA: route av_readdatavalid to the owner only. Count beats; the beat that makes
//    count==len returns to IDLE with owner=NONE. A valid beat in the accept cycle is counted too.
//  - WR_BURST: latch len on the first accepted beat. Count beats where av_write && !av_waitrequest.
//    Count reaching len -> IDLE.
//  - The owner dropping read/write mid-burst does not release the grant. The arbiter keeps
//    waiting for the remaining beats (av_write simply follows the owner).
//  - burstcount=0 is treated as 1. Counter is BURST_W bits and never wraps for len<=16.
//  - av_readdatavalid while in IDLE or RD_CMD-before-accept is dropped (not routed to any port).
//  - No back-to-back grant without an IDLE cycle: minimum 1 dead cycle between bursts.
//  - Reset mid-burst aborts immediately. Beats arriving after reset release are dropped by the
//    rule above.
// TESTING
//  1. D read burst 16 alone -> av_read 1 cycle after d_read; 16 d_readdatavalid; i_readdatavalid
//     stays 0; IDLE after the 16th beat.
//  2. I and D read requests in the same cycle after reset -> D granted first; I granted in the
//     cycle after D's 16th beat plus 1 IDLE cycle.
//  3. D write burst 16 with av_waitrequest toggling every other cycle -> exactly 16 beats
//     forwarded in order; i_waitrequest=1 throughout.
//  4. Both ports requesting continuously for 4 bursts -> grant order D,I,D,I.
//  5. resetn pulsed low during beat 5 of an I read -> outputs reach reset values asynchronously;
//     later av_readdatavalid beats never reach either port; next D request granted normally.
//  6. d_burstcount=0 read -> exactly one beat routed, then IDLE.

Source files
------------

// File: rtl/avalon_burst_arbiter.sv
// avalon_burst_arbiter: round-robin sharing of one Avalon-MM burst master between the I and D caches.
// The grant is held for a whole burst: every read beat returned or every write beat accepted.
module avalon_burst_arbiter #(
  parameter int BURST_W = 5,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [ADDR_W-1:0]  i_address,
  input  logic               i_read,
  input  logic [BURST_W-1:0] i_burstcount,
  output logic               i_waitrequest,
  output logic [DATA_W-1:0]  i_readdata,
  output logic               i_readdatavalid,
  input  logic [ADDR_W-1:0]  d_address,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [DATA_W-1:0]  d_writedata,
  input  logic [BURST_W-1:0] d_burstcount,
  output logic               d_waitrequest,
  output logic [DATA_W-1:0]  d_readdata,
  output logic               d_readdatavalid,
  output logic [ADDR_W-1:0]  av_address,
  output logic               av_read,
  output logic               av_write,
  output logic [DATA_W-1:0]  av_writedata,
  output logic [BURST_W-1:0] av_burstcount,
  input  logic               av_waitrequest,
  input  logic [DATA_W-1:0]  av_readdata,
  input  logic               av_readdatavalid
);
  typedef enum logic [1:0] {IDLE, RD_CMD, RD_DATA, WR_BURST} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;
  state_t state;
  owner_t owner;
  logic last_d;
  logic [BURST_W-1:0] cnt, len, bc_eff, cur_len, cnt_nxt;
  logic own_i, own_d, cmd_phase, rd_acc, rdv, wr_beat, beat, done, req_i, req_d, grant_d;
  always_comb begin
    own_i = owner == OWN_I;
    own_d = owner == OWN_D;
    av_address = own_i ? i_address : own_d ? d_address : '0;
    av_burstcount = own_i ? i_burstcount : own_d ? d_burstcount : '0;
    av_writedata = own_d ? d_writedata : '0;
    av_read = state == RD_CMD;
    av_write = state == WR_BURST && own_d && d_write;
    cmd_phase = state == RD_CMD || state == WR_BURST;
    i_waitrequest = !(own_i && cmd_phase) || av_waitrequest;
    d_waitrequest = !(own_d && cmd_phase) || av_waitrequest;
    rd_acc = state == RD_CMD && !av_waitrequest;
    // beats outside an accepted read burst belong to nobody
    rdv = av_readdatavalid && (state == RD_DATA || rd_acc);
    i_readdatavalid = rdv && own_i;
    d_readdatavalid = rdv && own_d;
    i_readdata = av_readdata;
    d_readdata = av_readdata;
    wr_beat = av_write && !av_waitrequest;
    beat = rdv || wr_beat;
    bc_eff = av_burstcount == '0 ? BURST_W'(1) : av_burstcount;
    cur_len = (rd_acc || (state == WR_BURST && cnt == '0)) ? bc_eff : len;
    cnt_nxt = cnt + BURST_W'(1);
    done = beat && cnt_nxt == cur_len;
    req_i = i_read;
    req_d = d_read || d_write;
    grant_d = req_d && (!req_i || !last_d);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      owner <= OWN_NONE;
      last_d <= 1'b0;
      cnt <= '0;
      len <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
      if (req_i || req_d) begin
        owner <= grant_d ? OWN_D : OWN_I;
        last_d <= grant_d;
        state <= (grant_d && d_write) ? WR_BURST : RD_CMD;
      end
    end else begin
      if (rd_acc || (wr_beat && cnt == '0)) len <= bc_eff;
      if (beat) cnt <= done ? '0 : cnt_nxt;
      if (done) begin
        state <= IDLE;
        owner <= OWN_NONE;
      end else if (rd_acc) state <= RD_DATA;
    end
  end
endmodule

// File: tb/tb_avalon_burst_arbiter.sv
// tb_avalon_burst_arbiter: scoreboard bench; stimulus queues expected beats, a negedge monitor checks them.
module tb_avalon_burst_arbiter;
  logic clk = 1'b0, resetn = 1'b0;
  logic [31:0] i_address = '0, d_address = '0, d_writedata = '0;
  logic i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
  logic [4:0] i_burstcount = '0, d_burstcount = '0;
  logic i_waitrequest, i_readdatavalid, d_waitrequest, d_readdatavalid;
  logic [31:0] i_readdata, d_readdata;
  logic [31:0] av_address, av_writedata;
  logic av_read, av_write;
  logic [4:0] av_burstcount;
  logic av_waitrequest = 1'b0, av_readdatavalid = 1'b0;
  logic [31:0] av_readdata = '0;

  avalon_burst_arbiter dut (
    .clk(clk), .resetn(resetn),
    .i_address(i_address), .i_read(i_read), .i_burstcount(i_burstcount),
    .i_waitrequest(i_waitrequest), .i_readdata(i_readdata), .i_readdatavalid(i_readdatavalid),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_writedata(d_writedata),
    .d_burstcount(d_burstcount), .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .d_readdatavalid(d_readdatavalid),
    .av_address(av_address), .av_read(av_read), .av_write(av_write), .av_writedata(av_writedata),
    .av_burstcount(av_burstcount), .av_waitrequest(av_waitrequest), .av_readdata(av_readdata),
    .av_readdatavalid(av_readdatavalid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  port;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  logic [31:0] mq[$];
  exp_t me;
  int cyc = 0, total = 0, bad = 0, n_i = 0, t_last_d = 0;
  logic stall_tog = 1'b0, watch = 1'b0, i_wr_low = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every routed read beat and every accepted write beat pops one expectation
  always @(negedge clk) begin
    if (i_readdatavalid || d_readdatavalid) begin
      if (sb.size() == 0) chk("stray_rdv", {30'b0, d_readdatavalid, i_readdatavalid}, 32'h0);
      else begin
        me = sb.pop_front();
        chk("rd_port", {30'b0, d_readdatavalid, i_readdatavalid}, {30'b0, me.port});
        chk("rd_data", d_readdatavalid ? d_readdata : i_readdata, me.data);
      end
      if (i_readdatavalid) n_i++;
      else t_last_d = cyc;
    end
    if (av_write && !av_waitrequest) begin
      if (sb.size() == 0) chk("stray_wr", {31'b0, av_write}, 32'h0);
      else begin
        me = sb.pop_front();
        chk("wr_addr", av_address, me.addr);
        chk("wr_data", av_writedata, me.data);
      end
    end
    if (watch && !i_waitrequest) i_wr_low = 1'b1;
  end

  // Memory: a burstcount of 0 returns a stray second beat that the arbiter must drop
  always @(negedge clk)
    if (av_read && !av_waitrequest)
      for (int k = 0; k < ((av_burstcount == 5'd0) ? 2 : int'(av_burstcount)); k++)
        mq.push_back(av_address + 32'(k));

  initial forever begin
    @(posedge clk);
    #1;
    av_waitrequest = stall_tog ? ~av_waitrequest : 1'b0;
    if (mq.size() > 0) begin
      av_readdatavalid = 1'b1;
      av_readdata = mq.pop_front();
    end else av_readdatavalid = 1'b0;
  end

  task automatic push_rd(input int port, input logic [31:0] a, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.port = 2'(port);
      e.addr = a;
      e.data = a + 32'(k);
      sb.push_back(e);
    end
  endtask

  task automatic rd_cmd(input bit is_d, input logic [31:0] a, input logic [4:0] bc, output int acc);
    logic got = 1'b0;
    acc = -1;
    if (is_d) begin d_address = a; d_burstcount = bc; d_read = 1'b1; end
    else begin i_address = a; i_burstcount = bc; i_read = 1'b1; end
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (is_d ? !d_waitrequest : !i_waitrequest) begin got = 1'b1; acc = cyc; end
    end
    chk(is_d ? "d_cmd_accept" : "i_cmd_accept", {31'b0, got}, 32'h1);
    @(posedge clk);
    #1;
    if (is_d) d_read = 1'b0;
    else i_read = 1'b0;
  endtask

  task automatic wr_burst(input logic [31:0] a, input logic [31:0] base, input int n);
    exp_t e;
    logic got;
    for (int k = 0; k < n; k++) begin
      e.port = 2'd3;
      e.addr = a;
      e.data = base + 32'(k);
      sb.push_back(e);
    end
    d_address = a;
    d_burstcount = 5'(n);
    d_write = 1'b1;
    for (int k = 0; k < n; k++) begin
      d_writedata = base + 32'(k);
      got = 1'b0;
      for (int j = 0; j < 50 && !got; j++) begin
        @(negedge clk);
        got = !d_waitrequest;
      end
      chk("wr_beat_accept", {31'b0, got}, 32'h1);
      @(posedge clk);
      #1;
    end
    d_write = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 500 && (sb.size() > 0 || mq.size() > 0); k++) @(negedge clk);
    chk("drain", 32'(sb.size() + mq.size()), 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s, a1, a2, a3, a4, n0;
    logic hit;
    // Reset state with non-zero port inputs: owner NONE must still drive zeros
    i_address = 32'h11; d_address = 32'h22; d_writedata = 32'h33;
    i_burstcount = 5'd3; d_burstcount = 5'd4;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_av_read", {31'b0, av_read}, 32'h0);
    chk("rst_av_write", {31'b0, av_write}, 32'h0);
    chk("rst_av_address", av_address, 32'h0);
    chk("rst_av_writedata", av_writedata, 32'h0);
    chk("rst_av_burstcount", {27'b0, av_burstcount}, 32'h0);
    chk("rst_waitreq", {30'b0, i_waitrequest, d_waitrequest}, 32'h3);
    chk("rst_rdv", {30'b0, i_readdatavalid, d_readdatavalid}, 32'h0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    // 1: lone D read of 16
    push_rd(2, 32'h1000, 16);
    s = cyc;
    rd_cmd(1'b1, 32'h1000, 5'd16, a1);
    chk("t1_latency", 32'(a1 - s), 32'h1);
    drain();
    chk("t1_idle", {30'b0, av_read, d_waitrequest}, 32'h1);
    // 2: simultaneous I and D after reset -> D first, I after one dead cycle
    do_reset();
    push_rd(2, 32'h2000, 16);
    push_rd(1, 32'h3000, 16);
    fork
      rd_cmd(1'b1, 32'h2000, 5'd16, a1);
      rd_cmd(1'b0, 32'h3000, 5'd16, a2);
    join
    drain();
    chk("t2_i_grant_cycle", 32'(a2), 32'(t_last_d + 2));
    // 4: both requesting continuously -> D,I,D,I
    push_rd(2, 32'h4000, 4);
    push_rd(1, 32'h4100, 4);
    push_rd(2, 32'h4200, 4);
    push_rd(1, 32'h4300, 4);
    fork
      begin rd_cmd(1'b1, 32'h4000, 5'd4, a1); rd_cmd(1'b1, 32'h4200, 5'd4, a3); end
      begin rd_cmd(1'b0, 32'h4100, 5'd4, a2); rd_cmd(1'b0, 32'h4300, 5'd4, a4); end
    join
    drain();
    // 3: D write burst with av_waitrequest toggling; I port stays stalled
    stall_tog = 1'b1;
    watch = 1'b1;
    wr_burst(32'h7000, 32'hA500, 16);
    watch = 1'b0;
    stall_tog = 1'b0;
    drain();
    chk("t3_i_waitreq_low_seen", {31'b0, i_wr_low}, 32'h0);
    chk("t3_idle", {30'b0, av_write, d_waitrequest}, 32'h1);
    // 6: burstcount 0 behaves as 1; the memory's extra beat must be dropped
    push_rd(2, 32'h8000, 1);
    rd_cmd(1'b1, 32'h8000, 5'd0, a1);
    drain();
    chk("t6_idle", {31'b0, av_read}, 32'h0);
    // 5: reset during beat 5 of an I read
    push_rd(1, 32'h5000, 16);
    n0 = n_i;
    rd_cmd(1'b0, 32'h5000, 5'd16, a1);
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(posedge clk);
      hit = n_i >= n0 + 4;
    end
    chk("t5_four_beats", {31'b0, hit}, 32'h1);
    #3;
    resetn = 1'b0;
    sb.delete();
    #1;
    chk("t5_async_rdv", {30'b0, i_readdatavalid, d_readdatavalid}, 32'h0);
    chk("t5_async_addr", av_address, 32'h0);
    chk("t5_async_bc", {27'b0, av_burstcount}, 32'h0);
    chk("t5_async_waitreq", {30'b0, i_waitrequest, d_waitrequest}, 32'h3);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    drain();
    push_rd(2, 32'h6000, 4);
    s = cyc;
    rd_cmd(1'b1, 32'h6000, 5'd4, a1);
    chk("t5_d_latency", 32'(a1 - s), 32'h1);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
